// File: rtl/keypad_operand_capture.sv
// keypad_operand_capture
// Turns debounced keypad presses into two decimal operands and an operator
// for the calculator datapath, and issues a one-cycle start strobe on equals.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   key_code   key code from the scanner, valid while key_valid=1
//   key_valid  high while a key is held
//   operand_a  first operand, unsigned binary
//   operand_b  second operand, unsigned binary
//   op_sel     00 add, 01 subtract, 10 multiply
//   calc_start one-cycle strobe, operands/op_sel frozen
//   entry_val  operand currently being typed (display)
//   digit_cnt  digits entered in the current operand
//   phase      00 ENTER_A, 01 ENTER_B, 10 RESULT
module keypad_operand_capture #(
    parameter int unsigned MAX_DIGITS = 3,
    parameter int unsigned OPW        = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     key_code,
    input  logic           key_valid,
    output logic [OPW-1:0] operand_a,
    output logic [OPW-1:0] operand_b,
    output logic [1:0]     op_sel,
    output logic           calc_start,
    output logic [OPW-1:0] entry_val,
    output logic [1:0]     digit_cnt,
    output logic [1:0]     phase
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        RESULT  = 2'b10
    } phase_t;

    phase_t           state_q, state_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic [OPW-1:0]   entry_q, entry_d;
    logic             key_valid_q;
    logic             rel_q;
    logic             press_c;
    logic             cnt_room_c;
    logic [OPW-1:0]   digit_c;

    // Rising edge of key_valid; rel_q masks the first cycle after reset
    // release so a key held through reset does not count as a press.
    assign press_c    = key_valid & ~key_valid_q & rel_q;
    assign cnt_room_c = (cnt_q < CNT_W'(MAX_DIGITS));
    assign digit_c    = OPW'(key_code);

    // Press detection history and reset-release qualifier
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_valid_q <= 1'b0;
            rel_q       <= 1'b0;
        end else begin
            key_valid_q <= key_valid;
            rel_q       <= 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            cnt_q   <= '0;
            start_q <= 1'b0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            entry_q <= entry_d;
        end
    end

    // Entry state machine: next state and next register values per key
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;

        if (press_c) begin
            if (key_code <= 4'h9) begin
                unique case (state_q)
                    ENTER_A: begin
                        if (cnt_room_c) begin
                            a_d   = OPW'(a_q * OPW'(10)) + digit_c;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    ENTER_B: begin
                        if (cnt_room_c) begin
                            b_d   = OPW'(b_q * OPW'(10)) + digit_c;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    RESULT: begin
                        // New calculation starts with this digit
                        a_d     = digit_c;
                        b_d     = '0;
                        op_d    = 2'b00;
                        cnt_d   = CNT_W'(1);
                        state_d = ENTER_A;
                    end
                    default: state_d = ENTER_A;
                endcase
            end else if (key_code <= 4'hC) begin
                // Operator: A moves to B; B may still change its mind
                // until the first B digit
                if (state_q == ENTER_A) begin
                    op_d    = 2'(key_code - 4'hA);
                    cnt_d   = '0;
                    state_d = ENTER_B;
                end else if (state_q == ENTER_B && cnt_q == '0) begin
                    op_d = 2'(key_code - 4'hA);
                end
            end else if (key_code == 4'hD) begin
                a_d     = '0;
                b_d     = '0;
                op_d    = 2'b00;
                cnt_d   = '0;
                state_d = ENTER_A;
            end else if (key_code == 4'hE) begin
                if (state_q == ENTER_B) begin
                    state_d = RESULT;
                    start_d = 1'b1;
                end
            end
        end

        entry_d = (state_d == ENTER_A) ? a_d : b_d;
    end

    assign operand_a  = a_q;
    assign operand_b  = b_q;
    assign op_sel     = op_q;
    assign calc_start = start_q;
    assign entry_val  = entry_q;
    assign digit_cnt  = cnt_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_keypad_operand_capture.sv
// Testbench for keypad_operand_capture: directed test-plan sequences plus
// random key presses, compared against a behavioural calculator-entry model.
module tb_keypad_operand_capture;

    localparam int unsigned MAXD = 3;
    localparam int unsigned OPW  = 10;

    logic           clk;
    logic           reset;
    logic [3:0]     key_code;
    logic           key_valid;
    logic [OPW-1:0] operand_a;
    logic [OPW-1:0] operand_b;
    logic [1:0]     op_sel;
    logic           calc_start;
    logic [OPW-1:0] entry_val;
    logic [1:0]     digit_cnt;
    logic [1:0]     phase;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0=ENTER_A, 1=ENTER_B, 2=RESULT
    int m_a, m_b, m_op, m_cnt, m_ph;

    keypad_operand_capture #(.MAX_DIGITS(MAXD), .OPW(OPW)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .op_sel     (op_sel),
        .calc_start (calc_start),
        .entry_val  (entry_val),
        .digit_cnt  (digit_cnt),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        m_a = 0; m_b = 0; m_op = 0; m_cnt = 0; m_ph = 0;
    endtask

    // Apply one key press to the model; st reports an expected start strobe
    task automatic mdl_key(input int k, output bit st);
        st = 1'b0;
        if (k <= 9) begin
            if (m_ph == 2) begin
                m_a = k; m_b = 0; m_op = 0; m_cnt = 1; m_ph = 0;
            end else if (m_cnt < MAXD) begin
                if (m_ph == 0) m_a = m_a * 10 + k;
                else           m_b = m_b * 10 + k;
                m_cnt++;
            end
        end else if (k <= 12) begin
            if (m_ph == 0) begin
                m_op = k - 10; m_cnt = 0; m_ph = 1;
            end else if (m_ph == 1 && m_cnt == 0) begin
                m_op = k - 10;
            end
        end else if (k == 13) begin
            mdl_reset();
        end else if (k == 14) begin
            if (m_ph == 1) begin
                m_ph = 2; st = 1'b1;
            end
        end
    endtask

    task automatic check_all(input bit exp_start);
        chk("operand_a",  int'(operand_a),  m_a);
        chk("operand_b",  int'(operand_b),  m_b);
        chk("op_sel",     int'(op_sel),     m_op);
        chk("calc_start", int'(calc_start), int'(exp_start));
        chk("entry_val",  int'(entry_val),  (m_ph == 0) ? m_a : m_b);
        chk("digit_cnt",  int'(digit_cnt),  m_cnt);
        chk("phase",      int'(phase),      m_ph);
    endtask

    // One press held for 'hold' cycles, then a single low cycle
    task automatic press(input logic [3:0] code, input int hold);
        bit st;
        @(negedge clk);
        key_code  = code;
        key_valid = 1'b1;
        @(posedge clk); #1;
        mdl_key(int'(code), st);
        check_all(st);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            key_code = 4'($urandom);
            @(posedge clk); #1;
            check_all(1'b0);
        end
        @(negedge clk);
        key_valid = 1'b0;
        @(posedge clk); #1;
        check_all(1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all(1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all(1'b0);

        // 123 + 45 =
        press(4'h1, 1); press(4'h2, 1); press(4'h3, 1); press(4'hA, 1);
        press(4'h4, 1); press(4'h5, 1); press(4'hE, 1);
        chk("tp1_a", int'(operand_a), 123);
        chk("tp1_b", int'(operand_b), 45);
        chk("tp1_phase", int'(phase), 2);

        // Fourth digit dropped
        press(4'hD, 1);
        press(4'h9, 2); press(4'h9, 1); press(4'h9, 3); press(4'h7, 1);
        chk("tp2_a", int'(operand_a), 999);
        chk("tp2_cnt", int'(digit_cnt), 3);

        // Long hold gives one event
        press(4'hD, 1);
        press(4'h5, 1000);
        chk("tp3_a", int'(operand_a), 5);
        chk("tp3_cnt", int'(digit_cnt), 1);

        // Operator replacement in ENTER_B, then 2 =
        press(4'hA, 1); press(4'hB, 1); press(4'hC, 1);
        press(4'h2, 1); press(4'hA, 1); press(4'hE, 1);
        chk("tp4_op", int'(op_sel), 2);
        chk("tp4_b", int'(operand_b), 2);

        // Digit in RESULT starts over, then clear
        press(4'hE, 1); press(4'hB, 1);
        press(4'h7, 1);
        chk("tp5_a", int'(operand_a), 7);
        chk("tp5_phase", int'(phase), 0);
        press(4'hD, 1);
        chk("tp5_clr_a", int'(operand_a), 0);

        // Reset mid-entry with key held through release
        press(4'h1, 1); press(4'hA, 1); press(4'h3, 1);
        @(negedge clk);
        key_code  = 4'h5;
        key_valid = 1'b1;
        reset     = 1'b0;
        #1;
        mdl_reset();
        check_all(1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check_all(1'b0);
        end
        @(negedge clk);
        key_valid = 1'b0;
        @(posedge clk); #1;
        check_all(1'b0);
        press(4'h5, 1);
        chk("tp6_a", int'(operand_a), 5);

        // Random presses, biased toward digits
        for (int n = 0; n < 400; n++) begin
            logic [3:0] k;
            if ($urandom_range(0, 2) == 0) k = 4'($urandom_range(10, 15));
            else                           k = 4'($urandom_range(0, 9));
            press(k, int'($urandom_range(1, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
